// File: rtl/ram_fifo_ctrl_if.sv
// Stream-side handshake bundle for ram_fifo_ctrl: write stream in (s_*), read stream out (m_*).
// master = producer/consumer environment, slave = the FIFO controller.
interface ram_fifo_ctrl_if #(
   parameter int unsigned DATA_W = 8
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;

   modport master (
      output s_valid,
      output s_data,
      output m_ready,
      input  s_ready,
      input  m_valid,
      input  m_data
   );

   modport slave (
      input  s_valid,
      input  s_data,
      input  m_ready,
      output s_ready,
      output m_valid,
      output m_data
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous RAM: buffers a valid/ready write
// stream in the RAM and replays it in order through a one-entry registered output stage.
module ram_fifo_ctrl #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_fifo_ctrl_if.slave    bus,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W+1:0] count,
   output logic              full,
   output logic              empty
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned OCC_W = ADDR_W + 2;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
   logic              rd_inflight_q, rd_inflight_d;
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;

   logic ram_full_c;
   logic rd_go_c;
   logic wr_go_c;
   logic s_ready_c;

   // Port arbitration: a read is issued whenever the output stage can absorb it; writes take the gaps.
   always_comb begin
      ram_full_c = (ram_cnt_q == CNT_W'(DEPTH));
      rd_go_c    = (ram_cnt_q != '0) && !rd_inflight_q && (!m_valid_q || bus.m_ready);
      s_ready_c  = !rd_go_c && !ram_full_c;
      wr_go_c    = bus.s_valid && s_ready_c;
   end

   assign bus.s_ready = s_ready_c;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;

   assign ram_we    = wr_go_c;
   assign ram_addr  = rd_go_c ? rd_ptr_q : wr_ptr_q;
   assign ram_wdata = bus.s_data;

   assign count = OCC_W'(ram_cnt_q) + OCC_W'(rd_inflight_q) + OCC_W'(m_valid_q);
   assign full  = ram_full_c;
   assign empty = (count == '0);

   // Next-state: pointers and RAM occupancy, then the read pipeline and output stage.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      ram_cnt_d     = ram_cnt_q;
      rd_inflight_d = 1'b0;
      m_valid_d     = m_valid_q;
      m_data_d      = m_data_q;

      if (wr_go_c) begin
         wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
         ram_cnt_d = ram_cnt_q + CNT_W'(1);
      end else if (rd_go_c) begin
         rd_ptr_d      = rd_ptr_q + ADDR_W'(1);
         ram_cnt_d     = ram_cnt_q - CNT_W'(1);
         rd_inflight_d = 1'b1;
      end

      // rd_go never fires while a capture is pending, so capture and consume cannot collide.
      if (rd_inflight_q) begin
         m_data_d  = ram_rdata;
         m_valid_d = 1'b1;
      end else if (m_valid_q && bus.m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ram_cnt_q     <= '0;
         rd_inflight_q <= 1'b0;
         m_valid_q     <= 1'b0;
         m_data_q      <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         ram_cnt_q     <= ram_cnt_d;
         rd_inflight_q <= rd_inflight_d;
         m_valid_q     <= m_valid_d;
         m_data_q      <= m_data_d;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural 16x8 RAM, scoreboard queue of accepted words
// checked in order against words consumed from the read port.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic [5:0] count;
   logic       full;
   logic       empty;

   logic [7:0] mem [16];
   logic [7:0] exp_q [$];

   int n_cmp  = 0;
   int n_fail = 0;

   ram_fifo_ctrl_if #(.DATA_W(8)) bus ();

   ram_fifo_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM model
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a falling edge with inputs already driven; samples handshakes, advances one cycle.
   task automatic step(output logic acc, output logic cons, output logic [7:0] cdata,
                       output logic [3:0] waddr);
      #1;
      acc   = bus.s_valid && bus.s_ready;
      cons  = bus.m_valid && bus.m_ready;
      cdata = bus.m_data;
      waddr = ram_addr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.s_valid = 1'($urandom);
         bus.s_data  = 8'($urandom);
         bus.m_ready = 1'($urandom);
         @(negedge clk);
         #1;
         n_cmp++;
         if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || empty !== 1'b1 ||
             count !== 6'd0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: m_valid=%b m_data=%h empty=%b count=%0d full=%b, need 0 00 1 0 0",
                     bus.m_valid, bus.m_data, empty, count, full);
         end
      end
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.s_ready !== 1'b1 || ram_we !== 1'b0 || count !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_release: s_ready=%b ram_we=%b count=%0d, need 1 0 0",
                  bus.s_ready, ram_we, count);
      end
   endtask

   task automatic test_single_write();
      logic acc, cons;
      logic [7:0] cd, e;
      logic [3:0] wa;
      do_reset();
      bus.m_ready = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hAA;
      #1;
      n_cmp++;
      if (ram_we !== 1'b1 || ram_addr !== 4'd0 || bus.s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_T: ram_we=%b ram_addr=%0d s_ready=%b, need 1 0 1", ram_we, ram_addr, bus.s_ready);
      end
      exp_q.push_back(8'hAA);
      @(posedge clk);
      @(negedge clk);
      bus.s_valid = 1'b0;
      #1;
      n_cmp++;
      if (ram_we !== 1'b0 || ram_addr !== 4'd0 || count !== 6'd1) begin
         n_fail++;
         $display("FAIL single_T1: ram_we=%b ram_addr=%0d count=%0d, need 0 0 1", ram_we, ram_addr, count);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.m_valid !== 1'b0 || count !== 6'd1) begin
         n_fail++;
         $display("FAIL single_T2: m_valid=%b count=%0d, need 0 1", bus.m_valid, count);
      end
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hAA || count !== 6'd1) begin
            n_fail++;
            $display("FAIL single_hold%0d: m_valid=%b m_data=%h count=%0d, need 1 aa 1",
                     i, bus.m_valid, bus.m_data, count);
         end
         @(negedge clk);
      end
      bus.m_ready = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
         step(acc, cons, cd, wa);
         if (cons) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (cd !== e) begin
               n_fail++;
               $display("FAIL single_out: got %h, need %h", cd, e);
            end
         end
      end
      bus.m_ready = 1'b0;
      #1;
      n_cmp++;
      if (exp_q.size() != 0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL single_drain: pending=%0d empty=%b, need 0 1", exp_q.size(), empty);
      end
   endtask

   task automatic test_fill();
      logic acc, cons;
      logic [7:0] cd;
      logic [3:0] wa;
      int idx = 0;
      do_reset();
      bus.m_ready = 1'b0;
      for (int c = 0; c < 80 && idx < 18; c++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(idx + 1);
         step(acc, cons, cd, wa);
         if (acc) begin
            exp_q.push_back(8'(idx + 1));
            idx++;
         end
      end
      #1;
      n_cmp++;
      if (idx != 17 || full !== 1'b1 || bus.s_ready !== 1'b0 || count !== 6'd17 || ram_we !== 1'b0) begin
         n_fail++;
         $display("FAIL fill: accepted=%0d full=%b s_ready=%b count=%0d ram_we=%b, need 17 1 0 17 0",
                  idx, full, bus.s_ready, count, ram_we);
      end
   endtask

   task automatic test_drain();
      logic acc, cons;
      logic [7:0] cd, e;
      logic [3:0] wa;
      int n = 0;
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
         step(acc, cons, cd, wa);
         if (cons) begin
            n++;
            e = exp_q.pop_front();
            n_cmp++;
            if (cd !== e) begin
               n_fail++;
               $display("FAIL drain_order: word %0d got %h, need %h", n, cd, e);
            end
         end
      end
      #1;
      n_cmp++;
      if (n != 17 || empty !== 1'b1 || count !== 6'd0 || ram_addr !== 4'd1) begin
         n_fail++;
         $display("FAIL drain_end: words=%0d empty=%b count=%0d ram_addr=%0d, need 17 1 0 1",
                  n, empty, count, ram_addr);
      end
      bus.m_ready = 1'b0;
   endtask

   task automatic test_contention();
      logic acc, cons, prev_acc;
      logic [7:0] cd, e;
      logic [3:0] wa;
      int sent = 0, got = 0, viol = 0, last_wr = -1;
      do_reset();
      bus.m_ready = 1'b1;
      prev_acc = 1'b0;
      for (int c = 0; c < 300; c++) begin
         bus.s_valid = (sent < 40);
         bus.s_data  = 8'(sent * 13 + 5);
         step(acc, cons, cd, wa);
         if (acc) begin
            n_cmp++;
            if (wa !== 4'(sent)) begin
               n_fail++;
               $display("FAIL contention_waddr: write %0d addr=%0d, need %0d", sent, wa, 4'(sent));
            end
            if (prev_acc) viol++;
            exp_q.push_back(8'(sent * 13 + 5));
            sent++;
            last_wr = c;
         end
         prev_acc = acc;
         if (cons) begin
            got++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL contention_extra: unexpected word %h", cd);
            end else begin
               e = exp_q.pop_front();
               n_cmp++;
               if (cd !== e) begin
                  n_fail++;
                  $display("FAIL contention_order: word %0d got %h, need %h", got, cd, e);
               end
            end
         end
         if (sent == 40 && exp_q.size() == 0) break;
      end
      n_cmp++;
      if (got != 40 || viol != 0 || last_wr != 78) begin
         n_fail++;
         $display("FAIL contention_rate: out=%0d b2b_writes=%0d last_write_cycle=%0d, need 40 0 78",
                  got, viol, last_wr);
      end
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic acc, cons;
      logic [7:0] cd, e;
      logic [3:0] wa;
      int n = 0;
      logic got_first = 1'b0;
      do_reset();
      bus.m_ready = 1'b0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(8'h30 + n);
         step(acc, cons, cd, wa);
         if (acc) n++;
      end
      bus.s_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      n_cmp++;
      if (count !== 6'd5 || bus.m_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre: count=%0d m_valid=%b, need 5 1", count, bus.m_valid);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.m_valid !== 1'b0 || count !== 6'd0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset: m_valid=%b count=%0d empty=%b, need 0 0 1", bus.m_valid, count, empty);
      end
      #2;
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      bus.m_ready = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h5C;
      step(acc, cons, cd, wa);
      if (acc) exp_q.push_back(8'h5C);
      bus.s_valid = 1'b0;
      for (int c = 0; c < 10 && !got_first; c++) begin
         step(acc, cons, cd, wa);
         if (cons) begin
            got_first = 1'b1;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL mid_first: got %h, need 5c (write not accepted)", cd);
            end else begin
               e = exp_q.pop_front();
               if (cd !== e) begin
                  n_fail++;
                  $display("FAIL mid_first: got %h, need %h", cd, e);
               end
            end
         end
      end
      n_cmp++;
      if (!got_first || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_after: output_seen=%b empty=%b, need 1 1", got_first, empty);
      end
      bus.m_ready = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      test_reset();
      test_single_write();
      test_fill();
      test_drain();
      test_contention();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller placed directly upstream of the team's single-port synchronous RAM (16 x 8).
- Accepts a valid/ready write stream, stores it in the RAM and streams it back out in order on a valid/ready read port.
- Owns the RAM's we/addr/data_in and consumes its data_out, so the RAM can serve as a rate-decoupling buffer between producer and consumer stages.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 8, data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  write-side data valid.
- s_ready  out  1  write-side ready; combinational.
- s_data  in  DATA_W  write data.
- m_valid  out  1  read-side data valid; registered.
- m_ready  in  1  read-side consumer ready.
- m_data  out  DATA_W  read data; registered.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_wdata  out  DATA_W  to RAM data_in.
- ram_rdata  in  DATA_W  from RAM data_out; valid the cycle after a read is presented.
- count  out  ADDR_W+2  total entries held (RAM + in-flight + output register).
- full  out  1  RAM slots exhausted.
- empty  out  1  count == 0.

Behaviour:
- One clock, clk. Asynchronous active-low reset rst_n.
- State: wr_ptr, rd_ptr (ADDR_W, wrap modulo DEPTH), ram_cnt (ADDR_W+1), rd_inflight (1), m_valid, m_data.
- Reset values: all state 0; outputs m_valid=0, m_data=0, full=0, empty=1, count=0, ram_we=0.
- RAM is single-port, so at most one access per cycle. Read has priority.
- rd_go = (ram_cnt != 0) and !rd_inflight and (!m_valid or m_ready).
- s_ready = !rd_go and (ram_cnt != DEPTH). This is a combinational path from m_ready to s_ready; accepted.
- wr_go = s_valid and s_ready.
- Port drive:
  - ram_we = wr_go.
  - ram_addr = rd_go ? rd_ptr : wr_ptr.
  - ram_wdata = s_data.
  - All combinational.
- On wr_go: wr_ptr++, ram_cnt++.
- On rd_go: rd_ptr++, ram_cnt--, rd_inflight <= 1. The slot is free for rewrite from the next cycle.
- When rd_inflight=1: m_data <= ram_rdata, m_valid <= 1, rd_inflight <= 0.
- When m_valid and m_ready and no capture that cycle: m_valid <= 0. A capture and a consume in the same cycle is impossible by construction of rd_go.
- m_data holds steady while m_valid=1 and m_ready=0.
- Latency: write accepted in cycle T, earliest read issue T+1, capture at end of T+2, m_valid=1 in T+3.
- Max sustained throughput is 1 entry per 2 cycles (shared port).
- count = ram_cnt + rd_inflight + m_valid. Max is DEPTH+1, because the output register holds one extra entry.
- full = (ram_cnt == DEPTH). empty = (count == 0).
- Pointer wrap: DEPTH-1 -> 0 silently.
- Simultaneous s_valid with rd_go: the read wins, s_ready=0 that cycle, and the producer holds its data.
- Reset mid-operation: all pointers and counts clear immediately. Any in-flight read is discarded and m_valid drops asynchronously. RAM contents are left intact but unreachable.

Test Plan:
1. Reset: assert rst_n=0 with random inputs -> m_valid=0, m_data=0x00, empty=1, count=0, s_ready=1 once released.
2. Single write, m_ready=0:
   - Drive s_data=0xAA for one accepted cycle T -> ram_we=1, ram_addr=0 in T.
   - T+1: ram_we=0, ram_addr=0.
   - T+3: m_valid=1, m_data=0xAA; stays stable for 5 cycles.
   - count=1 from T+1 onward.
3. Fill, m_ready=0:
   - Offer 0x01..0x12 continuously -> exactly 0x01..0x11 are accepted (17 entries).
   - Then full=1, s_ready=0, count=17; 0x12 is held with no write.
4. Drain after fill, m_ready=1 -> m_data sequence 0x01..0x11 in order, no duplicates or drops. Ends with empty=1, count=0, rd_ptr wrapped to 1.
5. Contention, m_ready=1 with a continuous producer -> s_ready alternates with rd_go. Output order matches input order over 40 words crossing the pointer wrap.
6. Reset mid-operation: hold 5 entries, pulse rst_n low mid-cycle for 3 ns -> m_valid drops immediately, count=0. A subsequent write of 0x5C is the first word out.
